// File: rtl/pc_ctrl.sv
// Program counter sequencer for a CHIP-8 style core.
// Drives an external return-address stack through push/pop strobes.
module pc_ctrl #(
   parameter logic [11:0] RESET_PC    = 12'h200,
   parameter int          STACK_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [11:0] addr,
   input  logic [7:0]  v0,
   output logic        op_ready,
   output logic [11:0] pc,
   output logic        stk_push,
   output logic        stk_pop,
   output logic [15:0] stk_data_in,
   input  logic [15:0] stk_data_out,
   output logic [4:0]  depth,
   output logic        fault
);

   localparam logic [2:0] OP_NEXT = 3'd0;
   localparam logic [2:0] OP_SKIP = 3'd1;
   localparam logic [2:0] OP_JP   = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_JPV0 = 3'd5;

   localparam logic [4:0] DEPTH_MAX = 5'(STACK_DEPTH);

   typedef enum logic [1:0] {
      RUN,
      RET_LOAD,
      FAULT
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] pc_q, pc_d;
   logic [4:0]  depth_q, depth_d;
   logic        fault_q, fault_d;
   logic        accept;

   assign op_ready = (state_q == RUN);
   assign accept   = op_valid && op_ready && !rst;
   assign pc       = pc_q;
   assign depth    = depth_q;
   assign fault    = fault_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      depth_d     = depth_q;
      fault_d     = fault_q;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_data_in = 16'h0000;
      unique case (state_q)
         RUN: begin
            if (accept) begin
               case (op)
                  OP_SKIP: pc_d = pc_q + 12'd4;
                  OP_JP:   pc_d = addr;
                  OP_JPV0: pc_d = addr + {4'h0, v0};
                  OP_CALL: begin
                     if (depth_q == DEPTH_MAX) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                     end else begin
                        stk_push    = 1'b1;
                        stk_data_in = {4'h0, pc_q + 12'd2};
                        pc_d        = addr;
                        depth_d     = depth_q + 5'd1;
                     end
                  end
                  OP_RET: begin
                     if (depth_q == 5'd0) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                     end else begin
                        state_d = RET_LOAD;
                     end
                  end
                  default: pc_d = pc_q + 12'd2;
               endcase
            end
         end
         RET_LOAD: begin
            // Reset in this cycle cancels the pop entirely
            if (!rst) begin
               stk_pop = 1'b1;
               pc_d    = stk_data_out[11:0];
               depth_d = depth_q - 5'd1;
               state_d = RUN;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         depth_q <= 5'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with a behavioural return-address stack.
module tb_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op;
   logic [11:0] addr;
   logic [7:0]  v0;
   logic        op_ready;
   logic [11:0] pc;
   logic        stk_push;
   logic        stk_pop;
   logic [15:0] stk_data_in;
   logic [15:0] stk_data_out;
   logic [4:0]  depth;
   logic        fault;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:15];
   int          sp = 0;

   always #5 clk = ~clk;

   pc_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .op_valid     (op_valid),
      .op           (op),
      .addr         (addr),
      .v0           (v0),
      .op_ready     (op_ready),
      .pc           (pc),
      .stk_push     (stk_push),
      .stk_pop      (stk_pop),
      .stk_data_in  (stk_data_in),
      .stk_data_out (stk_data_out),
      .depth        (depth),
      .fault        (fault)
   );

   // Stack stub: top entry visible combinationally, removed on a pop edge
   always_comb begin
      stk_data_out = 16'h0000;
      if (sp > 0) stk_data_out = mem[sp-1];
   end

   always @(posedge clk) begin
      if (rst) begin
         sp <= 0;
      end else if (stk_push && sp < 16) begin
         mem[sp] <= stk_data_in;
         sp <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         sp <= sp - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [2:0] o, input logic [11:0] a,
                        input logic [7:0] v);
      op_valid = 1'b1;
      op       = o;
      addr     = a;
      v0       = v;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      op_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      op_valid = 1'b0;
      op       = 3'd0;
      addr     = 12'h000;
      v0       = 8'h00;
      do_reset();
      chk("rst_pc", pc, 12'h200);
      chk("rst_depth", depth, 5'd0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_ready", op_ready, 1'b1);
      chk("rst_strobes", {stk_push, stk_pop}, 2'b00);

      apply(3'd0, 12'h000, 8'h00);
      chk("next_push", stk_push, 1'b0);
      chk("next_din", stk_data_in, 16'h0000);
      tick();
      chk("next1_pc", pc, 12'h202);
      apply(3'd0, 12'h000, 8'h00);
      tick();
      chk("next2_pc", pc, 12'h204);
      apply(3'd0, 12'h000, 8'h00);
      tick();
      chk("next3_pc", pc, 12'h206);
      chk("next_depth", depth, 5'd0);

      apply(3'd3, 12'h3A0, 8'h00);
      chk("call_push", stk_push, 1'b1);
      chk("call_pop", stk_pop, 1'b0);
      chk("call_din", stk_data_in, 16'h0208);
      tick();
      chk("call_pc", pc, 12'h3A0);
      chk("call_depth", depth, 5'd1);
      chk("call_push_off", stk_push, 1'b0);

      apply(3'd4, 12'h000, 8'h00);
      chk("ret_acc_strb", {stk_push, stk_pop}, 2'b00);
      tick();
      chk("ret_ld_ready", op_ready, 1'b0);
      chk("ret_ld_pop", stk_pop, 1'b1);
      chk("ret_ld_push", stk_push, 1'b0);
      chk("ret_ld_pc", pc, 12'h3A0);
      tick();
      chk("ret_pc", pc, 12'h208);
      chk("ret_depth", depth, 5'd0);
      chk("ret_ready", op_ready, 1'b1);
      chk("ret_pop_off", stk_pop, 1'b0);

      do_reset();
      apply(3'd3, 12'h300, 8'h00);
      chk("nest1_din", stk_data_in, 16'h0202);
      tick();
      apply(3'd3, 12'h400, 8'h00);
      chk("nest2_din", stk_data_in, 16'h0302);
      tick();
      chk("nest_pc", pc, 12'h400);
      chk("nest_depth", depth, 5'd2);
      apply(3'd4, 12'h000, 8'h00);
      tick();
      tick();
      chk("nret1_pc", pc, 12'h302);
      chk("nret1_depth", depth, 5'd1);
      apply(3'd4, 12'h000, 8'h00);
      tick();
      tick();
      chk("nret2_pc", pc, 12'h202);
      chk("nret2_depth", depth, 5'd0);

      apply(3'd5, 12'hFF0, 8'h20);
      tick();
      chk("jpv0_wrap", pc, 12'h010);
      apply(3'd2, 12'hFFE, 8'h00);
      tick();
      chk("jp_pc", pc, 12'hFFE);
      apply(3'd1, 12'h000, 8'h00);
      tick();
      chk("skip_wrap", pc, 12'h002);
      apply(3'd2, 12'hFFE, 8'h00);
      tick();
      apply(3'd0, 12'h000, 8'h00);
      tick();
      chk("next_wrap", pc, 12'h000);
      apply(3'd7, 12'h000, 8'h00);
      tick();
      chk("rsvd7_pc", pc, 12'h002);
      apply(3'd2, 12'h200, 8'h00);
      tick();
      apply(3'd1, 12'h000, 8'h00);
      tick();
      chk("skip_pc", pc, 12'h204);

      apply(3'd4, 12'h000, 8'h00);
      chk("uflow_strb", {stk_push, stk_pop}, 2'b00);
      tick();
      chk("uflow_fault", fault, 1'b1);
      chk("uflow_ready", op_ready, 1'b0);
      chk("uflow_pop", stk_pop, 1'b0);
      chk("uflow_pc", pc, 12'h204);
      apply(3'd0, 12'h000, 8'h00);
      tick();
      chk("fault_hold_pc", pc, 12'h204);
      chk("fault_sticky", fault, 1'b1);

      do_reset();
      chk("clr_fault", fault, 1'b0);
      for (int i = 0; i < 16; i++) begin
         apply(3'd3, 12'h100 + 12'(i * 16), 8'h00);
         chk("ovf_fill_push", stk_push, 1'b1);
         tick();
      end
      chk("full_depth", depth, 5'd16);
      chk("full_pc", pc, 12'h1F0);
      apply(3'd3, 12'h555, 8'h00);
      chk("ovf_push", stk_push, 1'b0);
      tick();
      chk("ovf_fault", fault, 1'b1);
      chk("ovf_depth", depth, 5'd16);
      chk("ovf_pc", pc, 12'h1F0);
      chk("ovf_ready", op_ready, 1'b0);
      tick();
      chk("ovf_ready2", op_ready, 1'b0);

      do_reset();
      apply(3'd3, 12'h3A0, 8'h00);
      tick();
      apply(3'd4, 12'h000, 8'h00);
      tick();
      rst = 1'b1;
      #1;
      chk("rstld_pop", stk_pop, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rstld_pc", pc, 12'h200);
      chk("rstld_depth", depth, 5'd0);
      chk("rstld_fault", fault, 1'b0);
      chk("rstld_ready", op_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 12'h200, PC value loaded on reset.
REQ-002 Parameter STACK_DEPTH, default 16, number of return-address entries the downstream stack holds.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 op_valid  input  1  control-flow operation presented this cycle.
REQ-006 op  input  3  0 NEXT, 1 SKIP, 2 JP, 3 CALL, 4 RET, 5 JPV0; 6 and 7 reserved.
REQ-007 addr  input  12  target address (NNN) for JP, CALL and JPV0.
REQ-008 v0  input  8  V0 register value used by JPV0.
REQ-009 op_ready  output  1  block accepts an op this cycle.
REQ-010 pc  output  12  current program counter, registered.
REQ-011 stk_push  output  1  push strobe to the stack.
REQ-012 stk_pop  output  1  pop strobe to the stack.
REQ-013 stk_data_in  output  16  value to push, {4'h0, return address}.
REQ-014 stk_data_out  input  16  current top-of-stack from the stack; only bits [11:0] are used.
REQ-015 depth  output  5  number of valid stack entries, 0..STACK_DEPTH.
REQ-016 fault  output  1  sticky stack overflow or underflow flag.

Function
REQ-017 The FSM SHALL have three states: RUN, RET_LOAD and FAULT.
REQ-018 An op SHALL be accepted only on a cycle where op_valid=1, op_ready=1 and rst=0.
REQ-019 op_ready SHALL be 1 in RUN and 0 in RET_LOAD and FAULT.
REQ-020 With no accepted op, pc, depth and state SHALL hold, and stk_push and stk_pop SHALL be 0.
REQ-021 NEXT (and reserved codes 6 and 7): pc <= pc+2.
REQ-022 SKIP: pc <= pc+4.
REQ-023 JP: pc <= addr.
REQ-024 JPV0: pc <= addr + zero-extended v0, truncated to 12 bits.
REQ-025 CALL with depth<STACK_DEPTH, in the accept cycle:
  - stk_push=1 (combinational);
  - stk_data_in={4'h0, pc+2};
  - pc <= addr;
  - depth <= depth+1.
REQ-026 RET with depth>0: the accept cycle SHALL move state to RET_LOAD with no strobe and no pc change.
REQ-027 In RET_LOAD:
  - stk_pop=1 (combinational);
  - pc <= stk_data_out[11:0];
  - depth <= depth-1;
  - state <= RUN.
  RET therefore occupies exactly 2 cycles.
REQ-028 The stack SHALL present the top entry on stk_data_out combinationally and remove it on the clock edge where stk_pop=1.
REQ-029 CALL with depth=STACK_DEPTH (overflow), or RET with depth=0 (underflow), SHALL:
  - set fault=1;
  - enter FAULT;
  - leave pc and depth unchanged;
  - assert no strobe.
REQ-030 FAULT SHALL be left only by rst.
REQ-031 All pc arithmetic SHALL wrap modulo 4096 (12'hFFE+2 = 12'h000; 12'hFFE+4 = 12'h002).
REQ-032 stk_push and stk_pop SHALL never both be 1 in the same cycle.
REQ-033 When stk_push=0, stk_data_in SHALL be 16'h0000.

Reset
REQ-034 While rst=1, stk_push=0 and stk_pop=0 regardless of state, and op_valid SHALL be ignored.
REQ-035 At the first rising edge with rst=1, the block SHALL load pc=RESET_PC, depth=0, fault=0 and state=RUN.
REQ-036 A reset asserted while in RET_LOAD SHALL cancel the pending pop; no pop strobe is issued and depth returns to 0.

Verification
REQ-037 Reset, then 3 NEXT ops -> pc sequence 200, 202, 204, 206; depth=0; no strobes.
REQ-038 From pc=0x206, CALL addr=0x3A0 -> one-cycle stk_push with stk_data_in=16'h0208; pc=0x3A0; depth=1.
  Then RET with stub stk_data_out=16'h0208 -> op_ready=0 for one cycle; stk_pop in the second cycle; pc=0x208; depth=0.
REQ-039 Nested CALLs 0x300 then 0x400, then two RETs -> pushed values 0x0202 then 0x0302; pcs after the RETs are 0x302 then 0x202; depth returns 1 then 0.
REQ-040 16 CALLs followed by a 17th CALL -> fault=1, depth=16, pc unchanged, no 17th push, op_ready=0 until rst.
  Separately, RET at depth=0 -> fault=1, no pop.
REQ-041 Wrap-around cases:
  - JPV0 addr=0xFF0, v0=0x20 -> pc=0x010.
  - SKIP at pc=0xFFE -> pc=0x002.
  - SKIP at pc=0x200 -> pc=0x204.
REQ-042 rst asserted in the RET_LOAD cycle -> stk_pop=0 that cycle; pc=0x200, depth=0, fault=0 after the edge.
